// File: rtl/rp_8bit_fetch.sv
// Instruction prefetch unit for a 16-bit word program memory with 16/32-bit instructions.
// Optional skip-next-instruction support is enabled with `define RP_8BIT_FETCH_SKIP_EN.
module rp_8bit_fetch #(
    parameter int unsigned PAW   = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           pmem_ce,
    output logic [PAW-1:0] pmem_adr,
    input  logic [15:0]    pmem_rdt,
    output logic           ins_vld,
    input  logic           ins_rdy,
    output logic [31:0]    ins_code,
    output logic           ins_len,
    output logic [PAW-1:0] ins_pc,
    input  logic           jmp_vld,
    input  logic [PAW-1:0] jmp_adr
`ifdef RP_8BIT_FETCH_SKIP_EN
    ,
    input  logic           ins_skp
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [15:0]    mem_q [DEPTH];
    logic [AW-1:0]  head_q, tail_q;
    logic [CW-1:0]  cnt_q;
    logic           infl_q;
    logic [PAW-1:0] fptr_q, pc_q;

    logic [15:0]    w0, w1;
    logic           is32, avail, present, pop, issue, push;
    logic [CW-1:0]  popn;

    assign w0 = mem_q[head_q];
    assign w1 = mem_q[head_q + AW'(1)];

    // lds/sts and jmp/call carry a second word
    assign is32 = ((w0[15:10] == 6'b100100) && (w0[3:0] == 4'b0000)) ||
                  ((w0[15:9] == 7'b1001010) && (w0[3:2] == 2'b11));

    assign avail = is32 ? (cnt_q >= CW'(2)) : (cnt_q != '0);

`ifdef RP_8BIT_FETCH_SKIP_EN
    logic skp_q;

    assign present = avail && !skp_q;
    assign pop     = (present && ins_rdy) || (avail && skp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skp_q <= 1'b0;
        end else if (jmp_vld) begin
            skp_q <= 1'b0;
        end else if (present && ins_rdy && ins_skp) begin
            skp_q <= 1'b1;
        end else if (pop) begin
            skp_q <= 1'b0;
        end
    end
`else
    assign present = avail;
    assign pop     = present && ins_rdy;
`endif

    assign popn  = pop ? (is32 ? CW'(2) : CW'(1)) : '0;
    assign push  = infl_q;
    assign issue = !jmp_vld && ((32'(cnt_q) + 32'(infl_q)) < DEPTH);

    // Reset gating keeps the read enable low while held in reset
    assign pmem_ce  = issue && rst_n;
    assign pmem_adr = fptr_q;

    assign ins_vld  = present;
    assign ins_code = present ? (is32 ? {w1, w0} : {16'h0000, w0}) : 32'h0;
    assign ins_len  = present && is32;
    assign ins_pc   = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            infl_q <= 1'b0;
            fptr_q <= '0;
            pc_q   <= '0;
        end else if (jmp_vld) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            infl_q <= 1'b0;
            fptr_q <= jmp_adr;
            pc_q   <= jmp_adr;
        end else begin
            if (push) begin
                tail_q <= tail_q + AW'(1);
            end
            head_q <= head_q + AW'(popn);
            cnt_q  <= cnt_q + CW'(push) - popn;
            infl_q <= issue;
            if (issue) begin
                fptr_q <= fptr_q + PAW'(1);
            end
            pc_q <= pc_q + PAW'(popn);
        end
    end

    // Returning read data lands at the tail unless a redirect cancels it
    always_ff @(posedge clk) begin
        if (push && !jmp_vld) begin
            mem_q[tail_q] <= pmem_rdt;
        end
    end

endmodule

// File: doc/rp_8bit_fetch.md
RP_8BIT_FETCH -- requirements
Module: rp_8bit_fetch

Interface
REQ-001 Parameter PAW, default 16, sets the program memory word address width.
REQ-002 Parameter DEPTH, default 4, sets the prefetch buffer depth in 16-bit words; legal values are powers of two, at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on the rising edge.
REQ-004 Port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 Port pmem_ce, output, 1 bit: program memory read enable.
REQ-006 Port pmem_adr, output, PAW bits: program memory word address.
REQ-007 Port pmem_rdt, input, 16 bits: read data, valid exactly 1 cycle after pmem_ce.
REQ-008 Port ins_vld, output, 1 bit: an instruction is presented to decode.
REQ-009 Port ins_rdy, input, 1 bit: decode accepts the instruction.
REQ-010 Port ins_code, output, 32 bits: {second word, first word}; the upper half is 0 for 16-bit instructions.
REQ-011 Port ins_len, output, 1 bit: 0 = 16-bit instruction, 1 = 32-bit instruction.
REQ-012 Port ins_pc, output, PAW bits: word address of the first word.
REQ-013 Port jmp_vld, input, 1 bit: redirect request.
REQ-014 Port jmp_adr, input, PAW bits: redirect target.

Function
REQ-015 32-bit instructions SHALL be detected from the first word only:
- lds/sts pattern 1001_00?_?????_0000
- jmp/call pattern 1001_010?_????_11??
- every other word is a 16-bit instruction.
REQ-016 Read issue rule:
- pmem_ce SHALL assert whenever (buffered words + in-flight reads) < DEPTH and no redirect is pending.
- pmem_adr SHALL equal the fetch pointer.
- The fetch pointer SHALL increment on each issue and wrap modulo 2^PAW.
REQ-017 The word returned 1 cycle after an issue SHALL be written into the buffer tail, unless that read was cancelled by a redirect.
REQ-018 ins_vld SHALL be 1 when the buffer holds at least 1 word and the head is 16-bit, or holds at least 2 words and the head is 32-bit; otherwise ins_vld SHALL be 0.
REQ-019 Handshake:
- A transfer occurs when ins_vld and ins_rdy are both 1 in the same cycle.
- On a transfer, 1 or 2 words (per ins_len) are popped and ins_pc advances by 1 or 2, modulo 2^PAW.
- ins_code, ins_len and ins_pc SHALL stay stable while ins_vld=1 and ins_rdy=0.
REQ-020 Minimum latency is 2 cycles from an issue to ins_vld for a 16-bit instruction. With ins_rdy held at 1, sustained throughput SHALL be one word per cycle.
REQ-021 Redirect (jmp_vld=1 in a cycle):
- Any transfer in that same cycle completes first.
- At the clock edge, the buffer is emptied and any in-flight read is cancelled.
- The fetch pointer and ins_pc are loaded with jmp_adr.
- ins_vld SHALL be 0 in the following cycle.
- The first issue to jmp_adr SHALL occur in the following cycle.
REQ-022 Back-to-back jmp_vld SHALL be honoured; the last request wins.
REQ-023 Simultaneous push and pop in one cycle SHALL be allowed, including when the buffer is full.

Reset
REQ-024 While rst_n=0, outputs SHALL be:
- pmem_ce=0, pmem_adr=0
- ins_vld=0, ins_code=0, ins_len=0, ins_pc=0
- buffer empty, no read in flight.
REQ-025 The first issue, to address 0, SHALL occur in the first clock edge after rst_n deasserts.
REQ-026 A reset asserted mid-operation SHALL discard buffered and in-flight words immediately and asynchronously.

Configuration
REQ-027 Macro RP_8BIT_FETCH_SKIP_EN, when defined:
- Adds port ins_skp, input, 1 bit, sampled only on a transfer.
- When ins_skp=1, the next complete instruction (16 or 32 bit, length per REQ-015) SHALL be popped without being presented (ins_vld=0 for it), and ins_pc advances past it.
- If that instruction is not yet fully buffered, the skip SHALL remain pending until it is.
- A redirect SHALL cancel a pending skip.
REQ-028 When RP_8BIT_FETCH_SKIP_EN is undefined, port ins_skp SHALL be absent and no skip logic SHALL exist.

Verification
REQ-029 Reset, ROM words 0x0000,0x0c01,0x9403 at addresses 0..2, ins_rdy=1 -> fetch order:
- address 0 is issued in the first cycle after reset release;
- ins_vld first rises 2 cycles later with ins_code=0x00000000, ins_pc=0;
- then ins_code=0x00000c01 at ins_pc=1.
REQ-030 Words 0x940c,0x1234 at address 5 -> a single transfer with ins_code=0x1234940c, ins_len=1, ins_pc=5; the next ins_pc is 7.
REQ-031 ins_rdy=0 for 10 cycles -> exactly DEPTH reads are issued, then pmem_ce=0, and the outputs stay stable; on ins_rdy=1, one transfer per cycle follows.
REQ-032 jmp_vld=1, jmp_adr=0x0100, issued while a read is in flight -> the next cycle has ins_vld=0 and pmem_adr=0x0100; the next instruction presented has ins_pc=0x0100; no stale word is ever presented.
REQ-033 Fetch pointer at 0xFFFF (PAW=16) -> the next issue is to 0x0000; a 32-bit instruction spanning the wrap presents ins_pc=0xFFFF.
REQ-034 With RP_8BIT_FETCH_SKIP_EN defined, transfer ins_skp=1 at pc 3 with a 32-bit instruction at 4 -> the next presented ins_pc is 6.
